decoder_pulse: RTL

- Temporal (time-to-pulse) decoder; sits directly downstream of the pulse output encoders. Converts NUM_LINES idle-high lines, each carrying at most one active-low pulse per frame, back into binary values.
- A frame is opened by frame_start. The slot in which each line first goes low encodes its value: the earliest slot gives MAX_VALUE, the latest gives 0.
- Results are presented as one registered vector with a valid/ready handshake, for consumption by the next layer or a readout stage.

---
 rtl/decoder_pulse.sv | 121 ++++++++++++
 1 files changed

// File: rtl/decoder_pulse.sv
// Time-to-pulse decoder: turns the slot of each line's first active-low pulse
// within a MAX_VALUE+1 slot window back into a binary value.
module decoder_pulse #(
    parameter int NUM_LINES = 4,
    parameter int MAX_VALUE = 8,
    localparam int W = $clog2(MAX_VALUE + 1)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   frame_start,
    input  logic [NUM_LINES-1:0]   incoming_lines,
    output logic [NUM_LINES*W-1:0] outgoing_values,
    output logic [NUM_LINES-1:0]   outgoing_missing,
    output logic                   outgoing_valid,
    input  logic                   outgoing_ready,
    output logic                   busy,
    output logic                   overrun
);

    // Handshake: outgoing_valid holds with stable values/missing until a cycle
    // where outgoing_valid && outgoing_ready; that cycle transfers the result.
    typedef enum logic [1:0] {S_IDLE, S_WINDOW, S_HOLD} state_t;

    localparam logic [W-1:0] MAX_W = W'(MAX_VALUE);

    state_t                 state_q, state_d;
    logic [W-1:0]           slot_q, slot_d;
    logic [NUM_LINES-1:0]   captured_q, captured_d;
    logic [NUM_LINES*W-1:0] values_q, values_d;
    logic [NUM_LINES-1:0]   missing_q, missing_d;
    logic                   valid_q, valid_d;
    logic                   busy_q, busy_d;
    logic                   overrun_q, overrun_d;
    logic [W-1:0]           slot_value;

    // slot_q never exceeds MAX_VALUE, so this cannot underflow.
    assign slot_value = MAX_W - slot_q;

    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        captured_d = captured_q;
        values_d   = values_q;
        missing_d  = missing_q;
        overrun_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    state_d    = S_WINDOW;
                    slot_d     = '0;
                    captured_d = '0;
                    values_d   = '0;
                    missing_d  = '0;
                end
            end
            S_WINDOW: begin
                for (int i = 0; i < NUM_LINES; i++) begin
                    if (!captured_q[i] && !incoming_lines[i]) begin
                        values_d[i*W +: W] = slot_value;
                        captured_d[i]      = 1'b1;
                    end
                end
                if (frame_start) overrun_d = 1'b1;
                if (slot_q == MAX_W) begin
                    state_d   = S_HOLD;
                    missing_d = ~captured_d;
                end else begin
                    slot_d = slot_q + W'(1);
                end
            end
            S_HOLD: begin
                if (outgoing_ready) begin
                    // A start coinciding with the handshake reopens the window directly.
                    if (frame_start) begin
                        state_d    = S_WINDOW;
                        slot_d     = '0;
                        captured_d = '0;
                        values_d   = '0;
                        missing_d  = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (frame_start) begin
                    overrun_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        valid_d = (state_d == S_HOLD);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            slot_q     <= '0;
            captured_q <= '0;
            values_q   <= '0;
            missing_q  <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            captured_q <= captured_d;
            values_q   <= values_d;
            missing_q  <= missing_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
        end
    end

    assign outgoing_values  = values_q;
    assign outgoing_missing = missing_q;
    assign outgoing_valid   = valid_q;
    assign busy             = busy_q;
    assign overrun          = overrun_q;

endmodule
